dwidth_down_1536_to_128: RTL and testbench

- Downstream width-down converter for the data router's wide 1536-bit output streams.
- Consumes one 1536-bit AXI-Stream word and serialises it into twelve 128-bit beats.
- Adds tkeep and frame-level tlast so the result can drive a 128-bit AXI DMA S2MM channel directly.
- It is the mirror of the 128-to-1536 input converters on the d/e paths; slice ordering matches them.

---
 rtl/dwidth_down_1536_to_128_if.sv | 42 ++++
 rtl/dwidth_down_1536_to_128.sv | 120 ++++++++++++
 tb/tb_dwidth_down_1536_to_128.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dwidth_down_1536_to_128_if.sv
// dwidth_down_1536_to_128_if
//   Stream bundle for the 1536-to-128 width-down converter: the wide input
//   stream (s_axis_*) and the narrow output stream (m_axis_*).
//
//   Modports:
//     slave  - the converter: accepts the wide stream and drives the
//              narrow one.
//     master - the surrounding traffic: drives the wide stream and sinks
//              the narrow one.
//
//   Signals:
//     s_axis_tdata  [IN_W]     wide input data
//     s_axis_tvalid            input valid
//     s_axis_tready            input ready
//     m_axis_tdata  [OUT_W]    narrow output data
//     m_axis_tvalid            output valid
//     m_axis_tready            output ready
//     m_axis_tkeep  [OUT_W/8]  byte enables
//     m_axis_tlast             final beat of a frame
interface dwidth_down_1536_to_128_if #(
    parameter int IN_W  = 1536,
    parameter int OUT_W = 128
);
    logic [IN_W-1:0]    s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic [OUT_W-1:0]   m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [OUT_W/8-1:0] m_axis_tkeep;
    logic               m_axis_tlast;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tkeep, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tkeep, m_axis_tlast
    );
endinterface

// File: rtl/dwidth_down_1536_to_128.sv
// dwidth_down_1536_to_128
//   Serialises each 1536-bit stream word into twelve 128-bit beats, slice 0
//   (bits [127:0]) first, and frames the output with tlast every
//   cfg_frame_words input words so it can feed a 128-bit DMA S2MM channel.
//   Back-to-back words stream with no bubble: the next word is loaded on the
//   same edge that retires the last slice of the current one.
//
//   Ports:
//     clk              clock
//     rst_n            synchronous active-low reset
//     cfg_frame_words  words per frame, sampled when a frame's first word loads
//                      (0 behaves as 1)
//     bus              stream bundle (slave modport), see the interface file
//
//   Optional build macro DDOWN_STATUS_EN adds:
//     frame_done       one-cycle pulse on the tlast handshake
//     frame_cnt [32]   completed-frame counter, wraps to 0
//
//   state | meaning
//   EMPTY | no word held, ready for a new wide word
//   SHIFT | word held in hold_q, presenting slice slc_q
module dwidth_down_1536_to_128 #(
    parameter int IN_W  = 1536,
    parameter int OUT_W = 128,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] cfg_frame_words,
    dwidth_down_1536_to_128_if.slave bus
`ifdef DDOWN_STATUS_EN
    ,
    output logic             frame_done,
    output logic [31:0]      frame_cnt
`endif
);
    localparam int RATIO = IN_W / OUT_W;
    localparam int SLC_W = $clog2(RATIO);

    typedef enum logic {
        EMPTY,
        SHIFT
    } state_t;

    state_t                        state_q;
    logic [RATIO-1:0][OUT_W-1:0]   hold_q;
    logic [SLC_W-1:0]              slc_q;
    logic [LEN_W-1:0]              wrd_q;
    logic [LEN_W-1:0]              len_q;

    logic             last_slc;
    logic             frame_end;
    logic             beat_acc;
    logic             s_ready;
    logic             load;
    logic             new_frame;
    logic [LEN_W-1:0] cfg_len;

    assign last_slc  = (slc_q == SLC_W'(RATIO - 1));
    assign frame_end = (wrd_q == len_q - LEN_W'(1));
    assign beat_acc  = (state_q == SHIFT) && bus.m_axis_tready;

    // Ready is combinational on m_axis_tready so the last-slice handshake and
    // the next load happen on the same edge.
    assign s_ready   = rst_n && ((state_q == EMPTY) || (beat_acc && last_slc));
    assign load      = s_ready && bus.s_axis_tvalid;

    // A load starts a new frame when the word counter is (or is about to wrap
    // to) zero; only then is the frame length resampled.
    assign new_frame = (state_q == EMPTY) ? (wrd_q == '0) : frame_end;
    assign cfg_len   = (cfg_frame_words == '0) ? LEN_W'(1) : cfg_frame_words;

    assign bus.s_axis_tready = s_ready;
    assign bus.m_axis_tvalid = rst_n && (state_q == SHIFT);
    assign bus.m_axis_tdata  = rst_n ? hold_q[slc_q] : '0;
    assign bus.m_axis_tlast  = bus.m_axis_tvalid && last_slc && frame_end;
    assign bus.m_axis_tkeep  = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            hold_q  <= '0;
            slc_q   <= '0;
            wrd_q   <= '0;
            len_q   <= LEN_W'(1);
        end else begin
            if (beat_acc) begin
                if (last_slc) begin
                    wrd_q <= frame_end ? '0 : wrd_q + LEN_W'(1);
                    if (!load) begin
                        state_q <= EMPTY;
                    end
                end else begin
                    slc_q <= slc_q + SLC_W'(1);
                end
            end
            if (load) begin
                hold_q  <= bus.s_axis_tdata;
                slc_q   <= '0;
                state_q <= SHIFT;
                if (new_frame) begin
                    len_q <= cfg_len;
                end
            end
        end
    end

`ifdef DDOWN_STATUS_EN
    assign frame_done = bus.m_axis_tlast && bus.m_axis_tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dwidth_down_1536_to_128.sv
// tb_dwidth_down_1536_to_128
//   Directed bench for the 1536-to-128 width-down converter. A source process
//   feeds queued wide words, a negedge monitor records accepted output beats,
//   and the main sequence compares them against hand-built expectations.
module tb_dwidth_down_1536_to_128;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_frame_words = 16'd1;
`ifdef DDOWN_STATUS_EN
    logic        frame_done;
    logic [31:0] frame_cnt;
`endif

    dwidth_down_1536_to_128_if bus ();

    dwidth_down_1536_to_128 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_frame_words (cfg_frame_words),
        .bus             (bus)
`ifdef DDOWN_STATUS_EN
        ,
        .frame_done      (frame_done),
        .frame_cnt       (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [1535:0] src_q[$];
    bit            rnd_rdy = 1'b0;

    logic [127:0]  beats[$];
    bit            lasts[$];
    int            cycs[$];
    bit            srs[$];
    int            in_cyc[$];
    logic [127:0]  exp_data[$];
    bit            exp_last[$];
    int            keep_err = 0;
    int            stab_err = 0;
    int            done_cnt = 0;

    bit            prev_stall = 1'b0;
    logic [127:0]  prev_data;
    logic          prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    // Source: presents src_q[0] and pops it once its handshake has happened.
    initial begin
        bit fire;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            fire = bus.s_axis_tvalid && bus.s_axis_tready;
            @(posedge clk);
            #1;
            if (fire && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = src_q[0];
            end else begin
                bus.s_axis_tvalid = 1'b0;
            end
            bus.m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: sampled mid-cycle, inputs only change just after posedge.
    always @(negedge clk) begin
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            beats.push_back(bus.m_axis_tdata);
            lasts.push_back(bus.m_axis_tlast);
            cycs.push_back(cyc);
            srs.push_back(bus.s_axis_tready);
            if (bus.m_axis_tkeep !== 16'hffff) keep_err++;
        end
        if (bus.s_axis_tvalid && bus.s_axis_tready) in_cyc.push_back(cyc);
        if (prev_stall && !(bus.m_axis_tvalid && bus.m_axis_tdata === prev_data &&
                            bus.m_axis_tlast === prev_last))
            stab_err++;
        prev_stall = rst_n && bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_data  = bus.m_axis_tdata;
        prev_last  = bus.m_axis_tlast;
`ifdef DDOWN_STATUS_EN
        if (frame_done) done_cnt++;
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1535:0] make_word(input int base);
        logic [1535:0] w;
        for (int k = 0; k < 12; k++) w[k*128 +: 128] = {16{8'(base + k)}};
        return w;
    endfunction

    task automatic push_word(input logic [1535:0] w, input bit last);
        src_q.push_back(w);
        for (int k = 0; k < 12; k++) begin
            exp_data.push_back(w[k*128 +: 128]);
            exp_last.push_back(last && k == 11);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t = 0;
        while (beats.size() < n && t < budget) begin
            step(1);
            t++;
        end
    endtask

    task automatic clear_all();
        beats.delete(); lasts.delete(); cycs.delete(); srs.delete();
        in_cyc.delete(); exp_data.delete(); exp_last.delete();
        keep_err = 0; stab_err = 0; done_cnt = 0;
    endtask

    task automatic check_stream(input string tag);
        int derr = 0;
        int lerr = 0;
        chk({tag, "_count"}, beats.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < beats.size(); i++) begin
            if (beats[i] !== exp_data[i]) derr++;
            if (lasts[i] !== exp_last[i]) lerr++;
        end
        chk({tag, "_data"}, derr, 0);
        chk({tag, "_tlast"}, lerr, 0);
        chk({tag, "_tkeep"}, keep_err, 0);
        chk({tag, "_stable"}, stab_err, 0);
    endtask

    initial begin
        int serr;

        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_s_tready", 32'(bus.s_axis_tready), 0);
        chk("rst_m_tvalid", 32'(bus.m_axis_tvalid), 0);
        chk("rst_m_tlast", 32'(bus.m_axis_tlast), 0);
        chk("rst_m_tdata_nonzero", 32'(|bus.m_axis_tdata), 0);
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_s_tready", 32'(bus.s_axis_tready), 1);
        chk("idle_m_tvalid", 32'(bus.m_axis_tvalid), 0);

        // Single word, one-word frame, slice k = {16{k}}
        clear_all();
        cfg_frame_words = 16'd1;
        step(1);
        push_word(make_word(0), 1'b1);
        wait_beats(12, 200);
        step(4);
        check_stream("single");
        if (cycs.size() > 0 && in_cyc.size() > 0)
            chk("single_latency", cycs[0] - in_cyc[0], 1);
        else
            chk("single_latency_seen", cycs.size() * in_cyc.size(), 1);

        // Back-to-back: 4 words, 2-word frames, continuous streaming
        clear_all();
        cfg_frame_words = 16'd2;
        step(1);
        push_word(make_word(8'h20), 1'b0);
        push_word(make_word(8'h30), 1'b1);
        push_word(make_word(8'h40), 1'b0);
        push_word(make_word(8'h50), 1'b1);
        wait_beats(48, 400);
        step(4);
        check_stream("b2b");
        serr = 0;
        for (int i = 0; i < srs.size(); i++)
            if (srs[i] != (i % 12 == 11)) serr++;
        chk("b2b_s_tready_pattern", serr, 0);
        if (cycs.size() == 48)
            chk("b2b_no_bubble", cycs[47] - cycs[0], 47);
        else
            chk("b2b_beats_seen", cycs.size(), 48);

        // Random backpressure, 3-word frames
        clear_all();
        cfg_frame_words = 16'd3;
        rnd_rdy = 1'b1;
        step(1);
        for (int w = 0; w < 6; w++)
            push_word(make_word(8'h60 + 16 * w), w == 2 || w == 5);
        wait_beats(72, 2000);
        step(4);
        rnd_rdy = 1'b0;
        step(2);
        check_stream("bp");

        // Length 0 acts as 1; a 3->5 change mid-frame waits for the frame end
        clear_all();
        cfg_frame_words = 16'd0;
        step(1);
        push_word(make_word(8'h01), 1'b1);
        push_word(make_word(8'h11), 1'b1);
        wait_beats(24, 400);
        cfg_frame_words = 16'd3;
        push_word(make_word(8'h21), 1'b0);
        wait_beats(25, 200);
        cfg_frame_words = 16'd5;
        push_word(make_word(8'h31), 1'b0);
        push_word(make_word(8'h41), 1'b1);
        for (int w = 0; w < 5; w++)
            push_word(make_word(8'h51 + 16 * w), w == 4);
        wait_beats(120, 1000);
        step(4);
        check_stream("cfg");

        // Reset while slice 6 of word 1 is on the output
        clear_all();
        cfg_frame_words = 16'd2;
        step(1);
        push_word(make_word(8'h05), 1'b0);
        src_q.push_back(make_word(8'h85));
        for (int k = 0; k < 6; k++) begin
            exp_data.push_back(128'({16{8'(8'h85 + k)}}));
            exp_last.push_back(1'b0);
        end
        wait_beats(18, 400);
        rst_n = 1'b0;
        step(1);
        @(negedge clk);
        chk("midrst_m_tvalid", 32'(bus.m_axis_tvalid), 0);
        chk("midrst_m_tlast", 32'(bus.m_axis_tlast), 0);
        chk("midrst_s_tready", 32'(bus.s_axis_tready), 0);
        step(1);
        rst_n = 1'b1;
        push_word(make_word(8'h95), 1'b0);
        push_word(make_word(8'hA5), 1'b1);
        wait_beats(42, 400);
        step(4);
        check_stream("midrst");

`ifdef DDOWN_STATUS_EN
        clear_all();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("stat_cnt_after_rst", int'(frame_cnt), 0);
        cfg_frame_words = 16'd1;
        step(1);
        push_word(make_word(8'h10), 1'b1);
        push_word(make_word(8'h70), 1'b1);
        push_word(make_word(8'hC0), 1'b1);
        wait_beats(36, 400);
        step(4);
        @(negedge clk);
        chk("stat_done_pulses", done_cnt, 3);
        chk("stat_frame_cnt", int'(frame_cnt), 3);
        step(1);
        rst_n = 1'b0;
        step(1);
        @(negedge clk);
        chk("stat_cnt_reset", int'(frame_cnt), 0);
        step(1);
        rst_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
